// File: rtl/fifo_uart_tx.sv
// ============================================================================
// fifo_uart_tx
//   Drains bytes from a synchronous FIFO and serializes them as async frames.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_rdata,
  output logic        fifo_re,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int                    c_baud_w    = $clog2(CLKS_PER_BIT);
  localparam logic [c_baud_w-1:0]   c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic                  c_stop_last = (STOP_BITS == 2);
  localparam logic                  c_par_en    = (PARITY_EN != 0);
  localparam logic                  c_par_odd   = (PARITY_ODD != 0);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_fetch  = 3'd1;
  localparam logic [2:0] c_st_load   = 3'd2;
  localparam logic [2:0] c_st_start  = 3'd3;
  localparam logic [2:0] c_st_data   = 3'd4;
  localparam logic [2:0] c_st_parity = 3'd5;
  localparam logic [2:0] c_st_stop   = 3'd6;

  logic [2:0]          r_state;
  logic [c_baud_w-1:0] r_baud;
  logic [2:0]          r_bit_idx;
  logic                r_stop_idx;
  logic [7:0]          r_shift;
  logic                r_tx;
  logic [15:0]         r_frames;

  logic [2:0]          w_state_next;
  logic [c_baud_w-1:0] w_baud_next;
  logic [2:0]          w_bit_idx_next;
  logic                w_stop_idx_next;
  logic                w_frame_done;
  logic                w_bit_end;
  logic                w_parity;
  logic                w_tx_next;
  logic                w_fifo_re;
  logic                w_busy;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_baud     <= '0;
      r_bit_idx  <= 3'd0;
      r_stop_idx <= 1'b0;
      r_shift    <= 8'h00;
      r_tx       <= 1'b1;
      r_frames   <= 16'h0000;
    end else begin
      r_state    <= w_state_next;
      r_baud     <= w_baud_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_tx       <= w_tx_next;
      if (r_state == c_st_load) begin
        r_shift <= fifo_rdata;
      end
      if (w_frame_done) begin
        r_frames <= r_frames + 16'd1;
      end
    end
  end

  assign w_bit_end = (r_baud == c_baud_last);
  assign w_parity  = (^r_shift) ^ c_par_odd;

  // Next-state logic; the baud counter only runs inside a frame
  always_comb begin
    w_state_next    = r_state;
    w_baud_next     = '0;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_frame_done    = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (enable && !fifo_empty) begin
          w_state_next = c_st_fetch;
        end
      end
      c_st_fetch: begin
        w_state_next = c_st_load;
      end
      c_st_load: begin
        w_state_next    = c_st_start;
        w_bit_idx_next  = 3'd0;
        w_stop_idx_next = 1'b0;
      end
      c_st_start: begin
        w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          w_state_next   = c_st_data;
          w_bit_idx_next = 3'd0;
        end
      end
      c_st_data: begin
        w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          if (r_bit_idx == 3'd7) begin
            w_state_next    = c_par_en ? c_st_parity : c_st_stop;
            w_stop_idx_next = 1'b0;
          end else begin
            w_bit_idx_next = r_bit_idx + 3'd1;
          end
        end
      end
      c_st_parity: begin
        w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          w_state_next    = c_st_stop;
          w_stop_idx_next = 1'b0;
        end
      end
      c_st_stop: begin
        w_baud_next = w_bit_end ? '0 : r_baud + 1'b1;
        if (w_bit_end) begin
          if (r_stop_idx == c_stop_last) begin
            w_state_next = c_st_idle;
            w_frame_done = 1'b1;
          end else begin
            w_stop_idx_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = c_st_idle;
      end
    endcase
  end

  // tx is registered from the upcoming state so the start bit lands at n+3
  always_comb begin
    w_tx_next = 1'b1;
    case (w_state_next)
      c_st_start:  w_tx_next = 1'b0;
      c_st_data:   w_tx_next = r_shift[w_bit_idx_next];
      c_st_parity: w_tx_next = w_parity;
      default:     w_tx_next = 1'b1;
    endcase
    w_fifo_re = (r_state == c_st_fetch);
    w_busy    = (r_state != c_st_idle);
  end

  assign fifo_re     = w_fifo_re;
  assign busy        = w_busy;
  assign tx          = r_tx;
  assign frames_sent = r_frames;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: three instances cover no-parity/1-stop,
// even-parity/2-stop and odd-parity/1-stop, each fed by its own FIFO model.
`default_nettype none

module tb_fifo_uart_tx;

  typedef struct packed {
    logic [7:0] b;
    logic       p;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  en;
  logic [2:0]  empty_w;
  logic [2:0]  re_w;
  logic [2:0]  tx_w;
  logic [2:0]  busy_w;
  logic [7:0]  rdata [3];
  logic [15:0] fs_w [3];

  logic [7:0]  mem [3][16];
  int          wr_ptr [3];
  int          rd_ptr [3] = '{0, 0, 0};
  int          re_cnt [3] = '{0, 0, 0};
  int          uf_cnt [3] = '{0, 0, 0};
  int          cyc = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  logic [15:0] fs_exp [3];
  int          nstart [3];
  int          done_cnt [3];
  int          start_log [3][16];
  int          n_chk;
  int          n_fail;

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .enable(en[0]), .fifo_empty(empty_w[0]),
    .fifo_rdata(rdata[0]), .fifo_re(re_w[0]), .tx(tx_w[0]), .busy(busy_w[0]),
    .frames_sent(fs_w[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .enable(en[1]), .fifo_empty(empty_w[1]),
    .fifo_rdata(rdata[1]), .fifo_re(re_w[1]), .tx(tx_w[1]), .busy(busy_w[1]),
    .frames_sent(fs_w[1]));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .enable(en[2]), .fifo_empty(empty_w[2]),
    .fifo_rdata(rdata[2]), .fifo_re(re_w[2]), .tx(tx_w[2]), .busy(busy_w[2]),
    .frames_sent(fs_w[2]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO read port models: data registered one cycle after re
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (re_w[k]) begin
        if (rd_ptr[k] == wr_ptr[k]) uf_cnt[k] <= uf_cnt[k] + 1;
        rdata[k]  <= mem[k][rd_ptr[k] % 16];
        rd_ptr[k] <= rd_ptr[k] + 1;
        re_cnt[k] <= re_cnt[k] + 1;
      end
    end
  end

  always_comb begin
    empty_w = 3'b111;
    for (int k = 0; k < 3; k++) empty_w[k] = (wr_ptr[k] == rd_ptr[k]);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic sb_push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int k, output exp_t e, output bit got);
    e = '0;
    got = 1'b1;
    case (k)
      0:       if (q0.size() == 0) got = 1'b0; else e = q0.pop_front();
      1:       if (q1.size() == 0) got = 1'b0; else e = q1.pop_front();
      default: if (q2.size() == 0) got = 1'b0; else e = q2.pop_front();
    endcase
  endtask

  task automatic push(input int k, input logic [7:0] b, input logic p);
    exp_t e;
    e.b = b;
    e.p = p;
    mem[k][wr_ptr[k] % 16] = b;
    wr_ptr[k] = wr_ptr[k] + 1;
    sb_push(k, e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: decodes each frame on tx cycle by cycle and checks it against the queue
  task automatic mon(input int k, input int pe, input int stops);
    exp_t e;
    bit   have;
    bit   ab;
    logic want;
    logic seen;
    int   nbits;
    nbits = 9 + pe + stops;
    forever begin
      @(negedge clk);
      if (reset !== 1'b0) begin
        fs_exp[k] = 16'h0000;
        continue;
      end
      if (tx_w[k] !== 1'b0) continue;
      start_log[k][nstart[k] % 16] = cyc;
      nstart[k] = nstart[k] + 1;
      sb_pop(k, e, have);
      if (!have) check($sformatf("dut%0d unexpected frame", k), 32'd1, 32'd0);
      ab = 1'b0;
      for (int bi = 0; bi < nbits && !ab; bi++) begin
        if (bi == 0) want = 1'b0;
        else if (bi <= 8) want = e.b[3'(bi - 1)];
        else if (pe != 0 && bi == 9) want = e.p;
        else want = 1'b1;
        seen = want;
        for (int c = 0; c < 4 && !ab; c++) begin
          if (bi != 0 || c != 0) @(negedge clk);
          if (reset !== 1'b0) ab = 1'b1;
          else if (tx_w[k] !== want) seen = tx_w[k];
        end
        if (!ab) begin
          check($sformatf("dut%0d byte %0h bit %0d", k, e.b, bi), {31'd0, seen}, {31'd0, want});
          if (bi == nbits - 1) begin
            check($sformatf("dut%0d frames_sent in last stop cycle", k), {16'd0, fs_w[k]}, {16'd0, fs_exp[k]});
            check($sformatf("dut%0d busy in last stop cycle", k), {31'd0, busy_w[k]}, 32'd1);
          end
        end
      end
      if (ab) begin
        fs_exp[k] = 16'h0000;
      end else begin
        @(negedge clk);
        fs_exp[k] = fs_exp[k] + 16'd1;
        check($sformatf("dut%0d frames_sent after frame", k), {16'd0, fs_w[k]}, {16'd0, fs_exp[k]});
        check($sformatf("dut%0d busy after frame", k), {31'd0, busy_w[k]}, 32'd0);
        done_cnt[k] = done_cnt[k] + 1;
      end
    end
  endtask

  task automatic wait_cnt(input string nm, input int k, input int n, input int lim, input bit use_start);
    int i;
    int v;
    i = 0;
    v = use_start ? nstart[k] : done_cnt[k];
    while (v < n && i < lim) begin
      tick(1);
      i++;
      v = use_start ? nstart[k] : done_cnt[k];
    end
    check(nm, (v >= n) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // n: IDLE with work pending; n+1 FETCH; n+2 LOAD; n+3 start bit
  task automatic check_latency(input string nm);
    @(negedge clk);
    check({nm, " re at n"}, {31'd0, re_w[0]}, 32'd0);
    @(negedge clk);
    check({nm, " re at n+1"}, {31'd0, re_w[0]}, 32'd1);
    check({nm, " busy at n+1"}, {31'd0, busy_w[0]}, 32'd1);
    @(negedge clk);
    check({nm, " re at n+2"}, {31'd0, re_w[0]}, 32'd0);
    check({nm, " tx at n+2"}, {31'd0, tx_w[0]}, 32'd1);
    @(negedge clk);
    check({nm, " tx at n+3"}, {31'd0, tx_w[0]}, 32'd0);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    for (int k = 0; k < 3; k++) begin
      wr_ptr[k] = 0;
      fs_exp[k] = 16'h0000;
      nstart[k] = 0;
      done_cnt[k] = 0;
    end
    reset = 1'b1;
    en = 3'b000;
    fork
      mon(0, 0, 1);
      mon(1, 1, 2);
      mon(2, 1, 1);
    join_none

    tick(3);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d reset tx", k), {31'd0, tx_w[k]}, 32'd1);
      check($sformatf("dut%0d reset re", k), {31'd0, re_w[k]}, 32'd0);
      check($sformatf("dut%0d reset busy", k), {31'd0, busy_w[k]}, 32'd0);
      check($sformatf("dut%0d reset frames_sent", k), {16'd0, fs_w[k]}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    en = 3'b111;
    tick(2);

    // Single byte 0xA5
    push(0, 8'hA5, 1'b0);
    check_latency("single");
    wait_cnt("single frame done", 0, 1, 80, 1'b0);
    check("single re count", re_cnt[0], 32'd1);

    // Parity instances run in parallel with the back-to-back test
    push(1, 8'h03, 1'b0);
    push(1, 8'h07, 1'b1);
    push(2, 8'h03, 1'b1);

    // Back-to-back
    tick(1);
    push(0, 8'h00, 1'b0);
    push(0, 8'hFF, 1'b0);
    push(0, 8'h3C, 1'b0);
    wait_cnt("b2b frames done", 0, 4, 300, 1'b0);
    check("b2b period 1-2", start_log[0][2] - start_log[0][1], 32'd43);
    check("b2b period 2-3", start_log[0][3] - start_log[0][2], 32'd43);
    check("b2b re count", re_cnt[0], 32'd4);
    check("b2b fifo empty", {31'd0, empty_w[0]}, 32'd1);
    tick(50);
    check("b2b no extra re", re_cnt[0], 32'd4);

    wait_cnt("parity even frames done", 1, 2, 300, 1'b0);
    wait_cnt("parity odd frame done", 2, 1, 300, 1'b0);
    check("parity dut1 re count", re_cnt[1], 32'd2);
    check("parity dut2 re count", re_cnt[2], 32'd1);

    // Enable gating
    en[0] = 1'b0;
    push(0, 8'h5A, 1'b0);
    push(0, 8'h12, 1'b0);
    repeat (100) begin
      @(negedge clk);
      check("gated idle re/tx/busy", {29'd0, re_w[0], tx_w[0], busy_w[0]}, 32'b010);
    end
    @(posedge clk);
    #1;
    en[0] = 1'b1;
    wait_cnt("gated frame starts", 0, 5, 20, 1'b1);
    tick(14);
    en[0] = 1'b0;
    wait_cnt("gated frame completes", 0, 5, 100, 1'b0);
    tick(60);
    check("gated re count", re_cnt[0], 32'd5);
    check("gated no new frame", nstart[0], 32'd5);

    // Reset during data bit 3
    en[0] = 1'b1;
    wait_cnt("reset frame starts", 0, 6, 20, 1'b1);
    tick(16);
    reset = 1'b1;
    push(0, 8'h81, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("mid reset tx", {31'd0, tx_w[0]}, 32'd1);
    check("mid reset busy", {31'd0, busy_w[0]}, 32'd0);
    check("mid reset frames_sent", {16'd0, fs_w[0]}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_latency("post reset");
    wait_cnt("post reset frame done", 0, 6, 80, 1'b0);
    check("post reset re count", re_cnt[0], 32'd7);

    for (int k = 0; k < 3; k++) begin
      check($sformatf("dut%0d underflow reads", k), uf_cnt[k], 32'd0);
    end
    check("dut0 scoreboard drained", q0.size(), 32'd0);
    check("dut1 scoreboard drained", q1.size(), 32'd0);
    check("dut2 scoreboard drained", q2.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the team's 16x8 synchronous FIFO. It drains bytes from the FIFO one at a time and serializes each one onto an asynchronous serial line. Each frame is 1 start bit, 8 data bits sent LSB first, an optional parity bit, and 1 or 2 stop bits. The block sits between the FIFO's read port and the chip-level TX pin, and provides the FIFO's `re` strobe itself.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range is 2 or more.
- STOP_BITS, default 1: number of stop bits; legal values are 1 or 2.
- PARITY_EN, default 0: when 1, a parity bit is inserted after data bit 7.
- PARITY_ODD, default 0: selects odd parity when 1 and even parity when 0. Ignored when PARITY_EN = 0.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  allows new frames to start. A frame already in progress always completes.
- fifo_empty  in  1  empty flag from the FIFO.
- fifo_rdata  in  8  FIFO read data. It is registered in the FIFO and valid the cycle after fifo_re is high.
- fifo_re  out  1  FIFO read strobe; one-cycle pulse per byte.
- tx  out  1  serial output; idle level is 1; registered.
- busy  out  1  high whenever the state is not IDLE.
- frames_sent  out  16  count of completed frames; wraps from 0xFFFF to 0x0000.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE -> FETCH when enable = 1 and fifo_empty = 0. Otherwise the FSM stays in IDLE.
- FETCH: lasts exactly 1 cycle.
  - fifo_re = 1 in this state only. fifo_re is decoded from the state, so no glitches and no second pulse.
  - FETCH -> LOAD unconditionally.
- LOAD: lasts 1 cycle. The shift register captures fifo_rdata. LOAD -> START.
- START: tx = 0 for CLKS_PER_BIT cycles, then -> DATA.
- DATA:
  - Bits 0..7 are sent LSB first, each held for CLKS_PER_BIT cycles.
  - A 3-bit index counts the bits.
  - After bit 7 the FSM goes to PARITY if PARITY_EN = 1, else to STOP.
- PARITY: tx = XOR of the 8 data bits, inverted when PARITY_ODD = 1. Held for CLKS_PER_BIT cycles, then -> STOP.
- STOP: tx = 1 for STOP_BITS × CLKS_PER_BIT cycles, then -> IDLE.
- frames_sent increments by 1 on the clock edge that leaves STOP.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - It counts 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary.
  - It is held at 0 in IDLE, FETCH and LOAD.
- enable is sampled only in IDLE. Deasserting enable mid-frame has no effect on the current frame.
- fifo_empty is sampled only in IDLE. Its value in FETCH or LOAD is ignored.
- The block never asserts fifo_re while fifo_empty = 1 in IDLE. This guarantees no underflow.
- Reset mid-frame: the frame is abandoned and the remaining bits are not sent. The byte already read from the FIFO is lost.

## Timing
- Reset values: tx = 1, fifo_re = 0, busy = 0, frames_sent = 0, state = IDLE, shift register = 0.
- tx returns to 1 on the first edge where reset is sampled high.
- Let cycle n be an IDLE cycle with enable = 1 and fifo_empty = 0. Then:
  - n+1: FETCH, fifo_re = 1, busy = 1.
  - n+2: LOAD.
  - n+3: first cycle of tx = 0 (start bit).
- Frame duration on tx, from start bit to the end of the last stop bit, is CLKS_PER_BIT × (9 + PARITY_EN + STOP_BITS) cycles.
- Back-to-back bytes:
  - STOP -> IDLE -> FETCH -> LOAD gives exactly 3 extra idle-high cycles between frames.
  - So the inter-frame period is frame duration + 3 cycles.
- busy:
  - Rises in the FETCH cycle.
  - Falls in the cycle the FSM re-enters IDLE.
- fifo_re pulse count equals the number of frames started. This holds with no exception except reset, which can cut a frame short after its read.

## Test plan
- Single byte, CLKS_PER_BIT = 4, no parity, 1 stop bit.
  - Stimulus: FIFO holds 0xA5; enable = 1.
  - Required response: fifo_re high for exactly 1 cycle.
  - tx from n+3 is 0, then bits 1,0,1,0,0,1,0,1, then 1. Each bit lasts 4 cycles, for a total of 40 cycles.
  - frames_sent = 1 and busy = 0 after the frame.
- Back-to-back: FIFO holds 0x00, 0xFF, 0x3C.
  - Required response: 3 frames, each separated by exactly 3 idle-high cycles.
  - Exactly 3 fifo_re pulses; frames_sent = 3.
  - The FIFO is empty afterwards and no further fifo_re occurs.
- Enable gating: FIFO non-empty with enable = 0 for 100 cycles.
  - Required response: fifo_re = 0, tx = 1, busy = 0 throughout.
  - Deassert enable in the middle of the DATA state: the current frame completes, and no new fifo_re is issued.
- Parity, PARITY_EN = 1.
  - Byte 0x03 with PARITY_ODD = 0: parity bit = 0.
  - Byte 0x03 with PARITY_ODD = 1: parity bit = 1.
  - Byte 0x07 with PARITY_ODD = 0: parity bit = 1.
- STOP_BITS = 2: tx is high for 2 × CLKS_PER_BIT cycles before IDLE. frames_sent increments only after the second stop bit.
- Reset mid-frame: assert reset during data bit 3.
  - Required response: next cycle tx = 1, busy = 0, frames_sent = 0.
  - After reset is released with the FIFO non-empty, a new frame starts with the normal 3-cycle latency.
